pwm_capture: RTL and testbench

//  Receive side of the PWM link: measures an incoming PWM waveform (high time and period, in clk

---
 rtl/pwm_capture.sv | 229 ++++++++++++++++++++++
 tb/tb_pwm_capture.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_capture
//  Description : PWM receive path. Measures high time and period (in clk
//                cycles) of an asynchronous PWM input and buffers each
//                complete measurement {high_cnt, period_cnt} in a small FIFO
//                for a host reader. Sticky flags report dropped records
//                (FIFO full) and missing edges (timeout).
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                pwm_in          - asynchronous PWM input
//                enable_i        - capture enable (0 returns to IDLE)
//                clear_i         - clears overflow_o / timeout_o
//                timeout_i       - no-edge timeout in cycles (0 = off)
//                rd_en_i         - FIFO read request
//                rdata           - {high_cnt, period_cnt}, valid after read
//                empty_o         - FIFO empty
//                overflow_o      - sticky record-dropped flag
//                timeout_o       - sticky timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture #(
    parameter int CNT_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pwm_in,
    input  logic                   enable_i,
    input  logic                   clear_i,
    input  logic [CNT_WIDTH-1:0]   timeout_i,
    input  logic                   rd_en_i,
    output logic [2*CNT_WIDTH-1:0] rdata,
    output logic                   empty_o,
    output logic                   overflow_o,
    output logic                   timeout_o
);

    localparam int                   c_AW      = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]        c_DEPTH   = (c_AW+1)'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ARM  = 2'd1;
    localparam logic [1:0] c_HIGH = 2'd2;
    localparam logic [1:0] c_LOW  = 2'd3;

    // ------------------------------------------------------------------
    // Input synchroniser and edge detect. Both edges see the same delay,
    // so the latency cancels out of every measurement.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_prev;
    assign w_fall = ~w_s & r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_prev <= w_s;
        end
    end

    // ------------------------------------------------------------------
    // Measurement state machine
    // ------------------------------------------------------------------
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;
    logic [CNT_WIDTH-1:0]   r_high;
    logic [CNT_WIDTH-1:0]   w_high_nxt;
    logic                   w_timeout_hit;
    logic                   w_push;
    logic                   w_timeout_set;
    logic [2*CNT_WIDTH-1:0] w_push_data;

    // Saturated counts stay at all-ones, so the record reports all-ones too.
    assign w_push_data = {r_high, r_cnt};

    always_comb begin
        w_cnt_inc     = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_ONE;
        w_timeout_hit = (timeout_i != '0) && (r_cnt == timeout_i);
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_high_nxt    = r_high;
        w_push        = 1'b0;
        w_timeout_set = 1'b0;
        if (!enable_i) begin
            // Partial measurement discarded; FIFO and flags untouched.
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ARM;
                end
                c_ARM: begin
                    if (w_rise) begin
                        w_cnt_nxt   = c_CNT_ONE;
                        w_state_nxt = c_HIGH;
                    end
                end
                c_HIGH: begin
                    // The expected edge takes priority over a timeout in the same cycle.
                    if (w_fall) begin
                        w_high_nxt  = r_cnt;
                        w_cnt_nxt   = w_cnt_inc;
                        w_state_nxt = c_LOW;
                    end else if (w_timeout_hit) begin
                        w_timeout_set = 1'b1;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = c_ARM;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin // c_LOW
                    if (w_rise) begin
                        // Rise closes this period and opens the next one.
                        w_push      = 1'b1;
                        w_cnt_nxt   = c_CNT_ONE;
                        w_state_nxt = c_HIGH;
                    end else if (w_timeout_hit) begin
                        w_timeout_set = 1'b1;
                        w_cnt_nxt     = '0;
                        w_state_nxt   = c_ARM;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_high  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_high  <= w_high_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Measurement FIFO (extra pointer bit distinguishes full from empty)
    // ------------------------------------------------------------------
    logic [2*CNT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW:0]          r_wr_ptr;
    logic [c_AW:0]          r_rd_ptr;
    logic [c_AW:0]          w_wr_ptr_nxt;
    logic [c_AW:0]          w_rd_ptr_nxt;
    logic [c_AW:0]          w_count;
    logic                   w_full;
    logic                   w_rd_acc;
    logic                   w_wr_acc;
    logic                   w_ovf_set;
    logic [2*CNT_WIDTH-1:0] r_rdata;
    logic                   r_empty;
    logic                   r_overflow;
    logic                   r_timeout;

    always_comb begin
        w_count   = r_wr_ptr - r_rd_ptr;
        w_full    = (w_count == c_DEPTH);
        w_rd_acc  = rd_en_i && !r_empty;
        // When full, a same-cycle read frees the slot being written.
        w_wr_acc  = w_push && (!w_full || w_rd_acc);
        w_ovf_set = w_push && w_full && !w_rd_acc;
        w_wr_ptr_nxt = w_wr_acc ? r_wr_ptr + (c_AW+1)'(1) : r_wr_ptr;
        w_rd_ptr_nxt = w_rd_acc ? r_rd_ptr + (c_AW+1)'(1) : r_rd_ptr;
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rdata  <= '0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            if (w_rd_acc) begin
                r_rdata <= r_mem[r_rd_ptr[c_AW-1:0]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky status flags: a set event beats a simultaneous clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_overflow <= w_ovf_set     ? 1'b1 : (clear_i ? 1'b0 : r_overflow);
            r_timeout  <= w_timeout_set ? 1'b1 : (clear_i ? 1'b0 : r_timeout);
        end
    end

    assign rdata      = r_rdata;
    assign empty_o    = r_empty;
    assign overflow_o = r_overflow;
    assign timeout_o  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_capture
//  Description : Self-checking bench for pwm_capture. A timestamp-based
//                model predicts records, FIFO contents and flags; outputs are
//                compared every cycle, plus literal expectations per scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

    localparam int CW    = 8;
    localparam int DEPTH = 4;
    localparam int SS    = 2;
    localparam int MAXC  = 255;

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_HIGH = 2;
    localparam int M_LOW  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            pwm_in;
    logic            enable_i;
    logic            clear_i;
    logic [CW-1:0]   timeout_i;
    logic            rd_en_i;
    logic [2*CW-1:0] rdata;
    logic            empty_o;
    logic            overflow_o;
    logic            timeout_o;

    int checks   = 0;
    int failures = 0;

    pwm_capture #(
        .CNT_WIDTH  (CW),
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .enable_i  (enable_i),
        .clear_i   (clear_i),
        .timeout_i (timeout_i),
        .rd_en_i   (rd_en_i),
        .rdata     (rdata),
        .empty_o   (empty_o),
        .overflow_o(overflow_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: works on timestamps of the synchronised input. A record is
    // {fall - rise, next_rise - rise}, clamped to all-ones.
    // ------------------------------------------------------------------
    logic            smp [SS+2];   // smp[k] = pwm_in sampled k edges ago
    int              mst    = M_IDLE;
    int              t_rise = 0;
    int              hlen   = 0;
    int              cyc    = 0;
    logic [2*CW-1:0] q [$];
    logic [2*CW-1:0] m_rdata = '0;
    logic            m_ovf   = 1'b0;
    logic            m_to    = 1'b0;
    bit              started = 1'b0;

    function automatic int sat(int k);
        return (k > MAXC) ? MAXC : k;
    endfunction

    task automatic model_step();
        logic s, p, rise, fall, push, to_set, ovf_set, rd_acc;
        int k;
        logic [2*CW-1:0] rec;
        cyc++;
        started = 1'b1;
        if (rst) begin
            foreach (smp[i]) smp[i] = 1'b0;
            mst = M_IDLE;
            q.delete();
            m_rdata = '0;
            m_ovf   = 1'b0;
            m_to    = 1'b0;
            return;
        end
        for (int i = SS + 1; i > 0; i--) smp[i] = smp[i-1];
        smp[0] = pwm_in;
        s = smp[SS];
        p = smp[SS+1];
        rise = s & ~p;
        fall = ~s & p;
        push = 1'b0; to_set = 1'b0; ovf_set = 1'b0; rec = '0;
        k = cyc - t_rise;
        if (!enable_i) begin
            mst = M_IDLE;
        end else begin
            case (mst)
                M_IDLE: mst = M_ARM;
                M_ARM: if (rise) begin t_rise = cyc; mst = M_HIGH; end
                M_HIGH: begin
                    if (fall) begin
                        hlen = sat(k); mst = M_LOW;
                    end else if (timeout_i != 0 && sat(k) == int'(timeout_i)) begin
                        to_set = 1'b1; mst = M_ARM;
                    end
                end
                default: begin
                    if (rise) begin
                        push = 1'b1; rec = {CW'(hlen), CW'(sat(k))};
                        t_rise = cyc; mst = M_HIGH;
                    end else if (timeout_i != 0 && sat(k) == int'(timeout_i)) begin
                        to_set = 1'b1; mst = M_ARM;
                    end
                end
            endcase
        end
        rd_acc = rd_en_i && (q.size() > 0);
        if (rd_acc) m_rdata = q.pop_front();
        if (push) begin
            if (q.size() < DEPTH) q.push_back(rec);
            else ovf_set = 1'b1;
        end
        m_ovf = ovf_set ? 1'b1 : (clear_i ? 1'b0 : m_ovf);
        m_to  = to_set  ? 1'b1 : (clear_i ? 1'b0 : m_to);
    endtask

    initial begin
        foreach (smp[i]) smp[i] = 1'b0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("cyc_rdata",    32'(rdata),      32'(m_rdata));
                check("cyc_empty",    32'(empty_o),    32'(q.size() == 0));
                check("cyc_overflow", 32'(overflow_o), 32'(m_ovf));
                check("cyc_timeout",  32'(timeout_o),  32'(m_to));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wave(int h, int l, int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1; step(h);
            pwm_in = 1'b0; step(l);
        end
    endtask

    task automatic read_lit(string name, logic [2*CW-1:0] exp);
        rd_en_i = 1'b1; step(1);
        rd_en_i = 1'b0;
        check(name, 32'(rdata), 32'(exp));
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1; step(1);
        clear_i = 1'b0;
    endtask

    task automatic disable_cap();
        enable_i = 1'b0; step(3);
    endtask

    initial begin
        rst = 1'b1; pwm_in = 1'b0; enable_i = 1'b0; clear_i = 1'b0;
        rd_en_i = 1'b0; timeout_i = '0;
        step(3);
        check("rst_rdata",    32'(rdata),      32'h0);
        check("rst_empty",    32'(empty_o),    32'h1);
        check("rst_overflow", 32'(overflow_o), 32'h0);
        check("rst_timeout",  32'(timeout_o),  32'h0);
        rst = 1'b0;
        step(2);

        // 1: 3 high / 5 low, four complete periods
        enable_i = 1'b1; step(4);
        wave(3, 5, 4);
        pwm_in = 1'b1; step(3); pwm_in = 1'b0; step(10);
        check("t1_not_empty", 32'(empty_o), 32'h0);
        for (int i = 0; i < 4; i++) read_lit("t1_rec", 16'h0308);
        check("t1_empty", 32'(empty_o), 32'h1);
        disable_cap();

        // 2: timeouts in HIGH and LOW, then an edge exactly at the limit
        timeout_i = 8'd20; enable_i = 1'b1; step(4);
        pwm_in = 1'b1; step(50);
        check("t2_to_high", 32'(timeout_o), 32'h1);
        check("t2_no_push", 32'(empty_o),   32'h1);
        pulse_clear();
        check("t2_clear", 32'(timeout_o), 32'h0);
        pwm_in = 1'b0; step(5);
        pwm_in = 1'b1; step(3); pwm_in = 1'b0; step(50);
        check("t2_to_low",   32'(timeout_o), 32'h1);
        check("t2_no_push2", 32'(empty_o),   32'h1);
        pulse_clear();
        wave(5, 15, 1);
        pwm_in = 1'b1; step(3); pwm_in = 1'b0; step(30);
        read_lit("t2_edge_wins", 16'h0514);
        check("t2_to_after", 32'(timeout_o), 32'h1);
        pulse_clear();
        timeout_i = '0;
        disable_cap();

        // 3: FIFO_DEPTH+2 periods with no reads
        enable_i = 1'b1; step(4);
        wave(2, 4, DEPTH + 2);
        pwm_in = 1'b1; step(2); pwm_in = 1'b0; step(10);
        check("t3_overflow", 32'(overflow_o), 32'h1);
        for (int i = 0; i < DEPTH; i++) read_lit("t3_rec", 16'h0206);
        check("t3_empty", 32'(empty_o), 32'h1);
        pulse_clear();
        check("t3_clear", 32'(overflow_o), 32'h0);
        disable_cap();

        // 4: full FIFO, push and read in the same cycle; read while empty
        enable_i = 1'b1; step(4);
        wave(2, 4, DEPTH);
        pwm_in = 1'b1; step(3); pwm_in = 1'b0; step(3);
        check("t4_full_no_ovf", 32'(overflow_o), 32'h0);
        pwm_in = 1'b1; step(1); step(SS - 1);
        rd_en_i = 1'b1; step(1); rd_en_i = 1'b0;
        check("t4_head", 32'(rdata), 32'h0206);
        step(2); pwm_in = 1'b0; step(10);
        check("t4_no_ovf", 32'(overflow_o), 32'h0);
        for (int i = 0; i < DEPTH - 1; i++) read_lit("t4_rec", 16'h0206);
        read_lit("t4_tail", 16'h0306);
        check("t4_empty", 32'(empty_o), 32'h1);
        read_lit("t4_rd_empty", 16'h0306);
        disable_cap();

        // 5: enable dropped mid-HIGH, re-enabled
        enable_i = 1'b1; step(4);
        pwm_in = 1'b1; step(5);
        enable_i = 1'b0; step(3);
        pwm_in = 1'b0; step(5);
        check("t5_no_partial", 32'(empty_o), 32'h1);
        enable_i = 1'b1; step(4);
        wave(3, 5, 1);
        pwm_in = 1'b1; step(3); pwm_in = 1'b0; step(10);
        read_lit("t5_clean", 16'h0308);
        check("t5_empty", 32'(empty_o), 32'h1);
        disable_cap();

        // 6: reset mid-LOW with two records stored and timeout set
        timeout_i = 8'd30; enable_i = 1'b1; step(4);
        wave(3, 5, 2);
        pwm_in = 1'b1; step(3); pwm_in = 1'b0; step(40);
        check("t6_stored", 32'(empty_o),   32'h0);
        check("t6_to_set", 32'(timeout_o), 32'h1);
        pwm_in = 1'b1; step(3); pwm_in = 1'b0; step(SS + 3);
        rst = 1'b1; step(1); rst = 1'b0;
        check("t6_empty", 32'(empty_o),    32'h1);
        check("t6_rdata", 32'(rdata),      32'h0);
        check("t6_to",    32'(timeout_o),  32'h0);
        check("t6_ovf",   32'(overflow_o), 32'h0);
        timeout_i = '0;
        disable_cap();

        // 7: saturation of both counts
        enable_i = 1'b1; step(4);
        pwm_in = 1'b1; step(300); pwm_in = 1'b0; step(10);
        pwm_in = 1'b1; step(3); pwm_in = 1'b0; step(5);
        read_lit("t7_sat", 16'hFFFF);
        disable_cap();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
